// File: rtl/dir_motion_ctrl.sv
// dir_motion_ctrl
// Turns a per-frame direction command into debounced cursor moves and
// selection steps. A command must stay stable for HOLD frames before the
// first action. While it is held, the action repeats every REPEAT frames.
//
// Ports
//   sys_clk      : single clock
//   reset_n      : asynchronous active-low reset
//   frame_tick   : one-cycle pulse per video frame; the command is sampled only then
//   pickMode     : 1 = selection mode (LRdir is used), 0 = movement mode (dir is used)
//   dir          : 0 idle, 1 up, 2 down, 3 left, 4 right, 5..7 idle
//   LRdir        : 0 idle, 1 previous, 2 next, 3..7 idle
//   pos_x, pos_y : registered cursor position
//   sel_idx      : registered selection index
//   move_valid   : one-cycle pulse when pos_x/pos_y actually changed
//   sel_valid    : one-cycle pulse on every select action
//   dbg_state_o  : current FSM state (IDLE=0, ARM=1, MOVE=2, RPT=3)
//   dbg_cnt_o    : current frame counter
//
// Handshake: there is no back-pressure. move_valid and sel_valid are
// valid-only strobes. Each strobe is high for exactly the first cycle in
// which the new value is visible on pos_x/pos_y or sel_idx.
module dir_motion_ctrl #(
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int X_INIT    = 320,
  parameter int Y_INIT    = 240,
  parameter int STEP      = 4,
  parameter int HOLD      = 3,
  parameter int REPEAT    = 8,
  parameter int SEL_COUNT = 5
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       pickMode,
  input  logic [2:0] dir,
  input  logic [2:0] LRdir,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [2:0] sel_idx,
  output logic       move_valid,
  output logic       sel_valid,
  output logic [1:0] dbg_state_o,
  output logic [3:0] dbg_cnt_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_MOVE = 2'd2;
  localparam logic [1:0] S_RPT  = 2'd3;

  // The command is {mode, code}. Every idle code collapses onto CMD_NONE.
  // A movement code and a select code with the same number therefore
  // remain distinct commands.
  localparam logic [3:0] CMD_NONE  = 4'b0000;
  localparam logic [3:0] CMD_UP    = 4'b0001;
  localparam logic [3:0] CMD_DOWN  = 4'b0010;
  localparam logic [3:0] CMD_LEFT  = 4'b0011;
  localparam logic [3:0] CMD_RIGHT = 4'b0100;
  localparam logic [3:0] CMD_PREV  = 4'b1001;
  localparam logic [3:0] CMD_NEXT  = 4'b1010;

  localparam logic [3:0]  HOLD_C     = 4'(HOLD);
  localparam logic [3:0]  REPEAT_C   = 4'(REPEAT);
  localparam logic [2:0]  SEL_LAST   = 3'(SEL_COUNT - 1);
  localparam logic [10:0] STEP_C     = 11'(STEP);
  localparam logic [10:0] X_MIN_W    = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W    = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_W    = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_W    = 11'(Y_MAX);
  localparam logic [9:0]  X_MIN_P    = 10'(X_MIN);
  localparam logic [9:0]  X_MAX_P    = 10'(X_MAX);
  localparam logic [9:0]  Y_MIN_P    = 10'(Y_MIN);
  localparam logic [9:0]  Y_MAX_P    = 10'(Y_MAX);
  localparam logic [9:0]  X_INIT_P   = 10'(X_INIT);
  localparam logic [9:0]  Y_INIT_P   = 10'(Y_INIT);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] lcmd_q, lcmd_d;
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;
  logic [2:0] sel_q, sel_d;
  logic       mv_q, mv_d;
  logic       sv_q, sv_d;

  logic [3:0]  cmd;
  logic [3:0]  cnt_inc;
  logic [10:0] x_w;
  logic [10:0] y_w;

  assign cnt_inc = cnt_q + 4'd1;
  assign x_w     = {1'b0, pos_x_q};
  assign y_w     = {1'b0, pos_y_q};

  always_comb begin
    cmd = CMD_NONE;
    if (pickMode) begin
      if (LRdir == 3'd1 || LRdir == 3'd2) cmd = {1'b1, LRdir};
    end else begin
      if (dir >= 3'd1 && dir <= 3'd4) cmd = {1'b0, dir};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcmd_d  = lcmd_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    sel_d   = sel_q;
    mv_d    = 1'b0;
    sv_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_tick && cmd != CMD_NONE) begin
          lcmd_d  = cmd;
          cnt_d   = 4'd1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (frame_tick) begin
          if (cmd == CMD_NONE) begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end else if (cmd != lcmd_q) begin
            lcmd_d = cmd;
            cnt_d  = 4'd1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == HOLD_C) state_d = S_MOVE;
          end
        end
      end
      S_MOVE: begin
        // Single action cycle. frame_tick is deliberately not looked at here.
        cnt_d   = 4'd0;
        state_d = S_RPT;
        case (lcmd_q)
          CMD_UP:    pos_y_d = (y_w < Y_MIN_W + STEP_C) ? Y_MIN_P : 10'(y_w - STEP_C);
          CMD_DOWN:  pos_y_d = (y_w + STEP_C > Y_MAX_W) ? Y_MAX_P : 10'(y_w + STEP_C);
          CMD_LEFT:  pos_x_d = (x_w < X_MIN_W + STEP_C) ? X_MIN_P : 10'(x_w - STEP_C);
          CMD_RIGHT: pos_x_d = (x_w + STEP_C > X_MAX_W) ? X_MAX_P : 10'(x_w + STEP_C);
          CMD_PREV: begin
            sel_d = (sel_q == 3'd0) ? SEL_LAST : sel_q - 3'd1;
            sv_d  = 1'b1;
          end
          CMD_NEXT: begin
            sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
            sv_d  = 1'b1;
          end
          default: ;
        endcase
        // A move clamped at the edge leaves the position unchanged, so it
        // must not produce a strobe.
        mv_d = (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
      end
      S_RPT: begin
        if (frame_tick) begin
          if (cmd != lcmd_q) begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == REPEAT_C) state_d = S_MOVE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      lcmd_q  <= CMD_NONE;
      pos_x_q <= X_INIT_P;
      pos_y_q <= Y_INIT_P;
      sel_q   <= 3'd0;
      mv_q    <= 1'b0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lcmd_q  <= lcmd_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      sel_q   <= sel_d;
      mv_q    <= mv_d;
      sv_q    <= sv_d;
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign sel_idx     = sel_q;
  assign move_valid  = mv_q;
  assign sel_valid   = sv_q;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_dir_motion_ctrl.sv
module tb_dir_motion_ctrl;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MOVE = 2'd2;
  localparam logic [1:0] ST_RPT  = 2'd3;

  logic       sys_clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       pickMode = 1'b0;
  logic [2:0] dir = 3'd0;
  logic [2:0] LRdir = 3'd0;

  logic [9:0] pos_x, pos_y, pos_x2, pos_y2;
  logic [2:0] sel_idx, sel_idx2;
  logic       move_valid, sel_valid, move_valid2, sel_valid2;
  logic [1:0] dbg_state, dbg_state2;
  logic [3:0] dbg_cnt, dbg_cnt2;

  int pass_cnt = 0;
  int total_cnt = 0;
  int mv_seen = 0;
  int sv_seen = 0;
  int mv2_seen = 0;
  int both_seen = 0;
  int snap_mv, snap_sv, snap_mv2;

  dir_motion_ctrl u_dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .pickMode(pickMode), .dir(dir), .LRdir(LRdir),
    .pos_x(pos_x), .pos_y(pos_y), .sel_idx(sel_idx),
    .move_valid(move_valid), .sel_valid(sel_valid),
    .dbg_state_o(dbg_state), .dbg_cnt_o(dbg_cnt)
  );

  dir_motion_ctrl #(.Y_INIT(2)) u_dut2 (
    .sys_clk(sys_clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .pickMode(pickMode), .dir(dir), .LRdir(LRdir),
    .pos_x(pos_x2), .pos_y(pos_y2), .sel_idx(sel_idx2),
    .move_valid(move_valid2), .sel_valid(sel_valid2),
    .dbg_state_o(dbg_state2), .dbg_cnt_o(dbg_cnt2)
  );

  // clock / pulse monitor
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (move_valid) mv_seen++;
    if (sel_valid) sv_seen++;
    if (move_valid2) mv2_seen++;
    if (move_valid && sel_valid) both_seen++;
  end

  // driver tasks
  task automatic do_tick();
    @(negedge sys_clk);
    frame_tick = 1'b1;
    @(negedge sys_clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    reset_n = 1'b0;
    @(negedge sys_clk);
    reset_n = 1'b1;
  endtask

  // tests
  task automatic test_reset();
    wait_cyc(2);
    @(negedge sys_clk);
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (pos_x !== 10'd320) $display("FAIL reset_pos_x: got %0d want 320", pos_x); else pass_cnt++;
    total_cnt++; if (pos_y !== 10'd240) $display("FAIL reset_pos_y: got %0d want 240", pos_y); else pass_cnt++;
    total_cnt++; if (sel_idx !== 3'd0) $display("FAIL reset_sel: got %0d want 0", sel_idx); else pass_cnt++;
    total_cnt++; if (move_valid !== 1'b0 || sel_valid !== 1'b0) $display("FAIL reset_valids: got %b%b want 00", move_valid, sel_valid); else pass_cnt++;
    total_cnt++; if (dbg_state !== ST_IDLE || dbg_cnt !== 4'd0) $display("FAIL reset_fsm: got st=%0d cnt=%0d want 0/0", dbg_state, dbg_cnt); else pass_cnt++;
    total_cnt++; if (pos_y2 !== 10'd2) $display("FAIL reset_dut2_y: got %0d want 2", pos_y2); else pass_cnt++;
    @(negedge sys_clk);
    reset_n = 1'b1;
  endtask

  task automatic test_move_right();
    dir = 3'd4;
    wait_cyc(1);
    snap_mv = mv_seen;
    do_tick(); do_tick();
    total_cnt++; if (dbg_state !== ST_ARM || dbg_cnt !== 4'd2) $display("FAIL right_arm: got st=%0d cnt=%0d want 1/2", dbg_state, dbg_cnt); else pass_cnt++;
    do_tick();
    total_cnt++; if (dbg_state !== ST_MOVE || pos_x !== 10'd320) $display("FAIL right_move_cycle: got st=%0d x=%0d want 2/320", dbg_state, pos_x); else pass_cnt++;
    @(negedge sys_clk);
    total_cnt++; if (pos_x !== 10'd324 || move_valid !== 1'b1) $display("FAIL right_first: got x=%0d mv=%b want 324/1", pos_x, move_valid); else pass_cnt++;
    @(negedge sys_clk);
    total_cnt++; if (move_valid !== 1'b0 || dbg_state !== ST_RPT) $display("FAIL right_pulse_len: got mv=%b st=%0d want 0/3", move_valid, dbg_state); else pass_cnt++;
    repeat (7) do_tick();
    total_cnt++; if (pos_x !== 10'd324 || dbg_cnt !== 4'd7) $display("FAIL right_rpt_wait: got x=%0d cnt=%0d want 324/7", pos_x, dbg_cnt); else pass_cnt++;
    do_tick();
    @(negedge sys_clk);
    total_cnt++; if (pos_x !== 10'd328 || move_valid !== 1'b1) $display("FAIL right_repeat: got x=%0d mv=%b want 328/1", pos_x, move_valid); else pass_cnt++;
    wait_cyc(2);
    total_cnt++; if (mv_seen - snap_mv !== 2) $display("FAIL right_pulse_count: got %0d want 2", mv_seen - snap_mv); else pass_cnt++;
    total_cnt++; if (sel_idx !== 3'd0 || pos_y !== 10'd240) $display("FAIL right_side_effects: got sel=%0d y=%0d want 0/240", sel_idx, pos_y); else pass_cnt++;
    dir = 3'd0;
    do_tick();
    total_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL right_release: got st=%0d want 0", dbg_state); else pass_cnt++;
  endtask

  task automatic test_short_hold();
    dir = 3'd1;
    wait_cyc(1);
    snap_mv = mv_seen;
    do_tick(); do_tick();
    dir = 3'd0;
    do_tick();
    total_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL short_abort: got st=%0d want 0", dbg_state); else pass_cnt++;
    wait_cyc(3);
    total_cnt++; if (pos_y !== 10'd240 || mv_seen - snap_mv !== 0) $display("FAIL short_no_move: got y=%0d pulses=%0d want 240/0", pos_y, mv_seen - snap_mv); else pass_cnt++;
    dir = 3'd6;
    do_tick();
    total_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL dir6_idle: got st=%0d want 0", dbg_state); else pass_cnt++;
    dir = 3'd0;
    pickMode = 1'b1; LRdir = 3'd5;
    do_tick();
    total_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL lr5_idle: got st=%0d want 0", dbg_state); else pass_cnt++;
    pickMode = 1'b0; LRdir = 3'd0;
  endtask

  task automatic test_clamp();
    apply_reset();
    dir = 3'd1;
    wait_cyc(1);
    snap_mv2 = mv2_seen;
    do_tick(); do_tick(); do_tick();
    @(negedge sys_clk);
    total_cnt++; if (pos_y2 !== 10'd0 || move_valid2 !== 1'b1) $display("FAIL clamp_first: got y=%0d mv=%b want 0/1", pos_y2, move_valid2); else pass_cnt++;
    total_cnt++; if (pos_y !== 10'd236) $display("FAIL up_first: got y=%0d want 236", pos_y); else pass_cnt++;
    repeat (8) do_tick();
    wait_cyc(3);
    total_cnt++; if (mv2_seen - snap_mv2 !== 1 || pos_y2 !== 10'd0) $display("FAIL clamp_noop: got pulses=%0d y=%0d want 1/0", mv2_seen - snap_mv2, pos_y2); else pass_cnt++;
    total_cnt++; if (pos_y !== 10'd232) $display("FAIL up_repeat: got y=%0d want 232", pos_y); else pass_cnt++;
    dir = 3'd0;
    do_tick();
  endtask

  task automatic test_select();
    pickMode = 1'b1; LRdir = 3'd1;
    wait_cyc(1);
    snap_sv = sv_seen;
    snap_mv = mv_seen;
    do_tick(); do_tick(); do_tick();
    total_cnt++; if (sel_idx !== 3'd0) $display("FAIL prev_latency: got sel=%0d want 0", sel_idx); else pass_cnt++;
    @(negedge sys_clk);
    total_cnt++; if (sel_idx !== 3'd4 || sel_valid !== 1'b1 || move_valid !== 1'b0) $display("FAIL prev_wrap: got sel=%0d sv=%b mv=%b want 4/1/0", sel_idx, sel_valid, move_valid); else pass_cnt++;
    LRdir = 3'd0;
    do_tick();
    LRdir = 3'd2;
    do_tick(); do_tick(); do_tick();
    @(negedge sys_clk);
    total_cnt++; if (sel_idx !== 3'd0 || sel_valid !== 1'b1) $display("FAIL next_wrap: got sel=%0d sv=%b want 0/1", sel_idx, sel_valid); else pass_cnt++;
    repeat (8) do_tick();
    @(negedge sys_clk);
    total_cnt++; if (sel_idx !== 3'd1 || sel_valid !== 1'b1) $display("FAIL next_repeat: got sel=%0d sv=%b want 1/1", sel_idx, sel_valid); else pass_cnt++;
    wait_cyc(2);
    total_cnt++; if (sv_seen - snap_sv !== 3 || mv_seen - snap_mv !== 0) $display("FAIL select_pulses: got sv=%0d mv=%0d want 3/0", sv_seen - snap_sv, mv_seen - snap_mv); else pass_cnt++;
    total_cnt++; if (pos_x !== 10'd320 || pos_y !== 10'd232) $display("FAIL select_pos_kept: got x=%0d y=%0d want 320/232", pos_x, pos_y); else pass_cnt++;
    LRdir = 3'd0;
    do_tick();
  endtask

  task automatic test_mode_toggle();
    pickMode = 1'b0; dir = 3'd2; LRdir = 3'd2;
    wait_cyc(1);
    snap_mv = mv_seen;
    snap_sv = sv_seen;
    do_tick(); do_tick();
    pickMode = 1'b1;
    do_tick();
    total_cnt++; if (dbg_state !== ST_ARM || dbg_cnt !== 4'd1) $display("FAIL toggle_restart: got st=%0d cnt=%0d want 1/1", dbg_state, dbg_cnt); else pass_cnt++;
    do_tick();
    total_cnt++; if (dbg_state !== ST_ARM || sel_idx !== 3'd1) $display("FAIL toggle_tick4: got st=%0d sel=%0d want 1/1", dbg_state, sel_idx); else pass_cnt++;
    do_tick();
    @(negedge sys_clk);
    total_cnt++; if (sel_idx !== 3'd2 || sel_valid !== 1'b1) $display("FAIL toggle_tick5: got sel=%0d sv=%b want 2/1", sel_idx, sel_valid); else pass_cnt++;
    wait_cyc(2);
    total_cnt++; if (mv_seen - snap_mv !== 0 || pos_y !== 10'd232 || sv_seen - snap_sv !== 1) $display("FAIL toggle_no_move: got mv=%0d y=%0d sv=%0d want 0/232/1", mv_seen - snap_mv, pos_y, sv_seen - snap_sv); else pass_cnt++;
    pickMode = 1'b0; dir = 3'd0; LRdir = 3'd0;
    do_tick();
  endtask

  task automatic test_reset_mid_rpt();
    apply_reset();
    dir = 3'd4;
    do_tick(); do_tick(); do_tick();
    @(negedge sys_clk);
    total_cnt++; if (pos_x !== 10'd324) $display("FAIL rst_pre_move: got x=%0d want 324", pos_x); else pass_cnt++;
    repeat (4) do_tick();
    #2;
    snap_mv = mv_seen;
    total_cnt++; if (dbg_state !== ST_RPT) $display("FAIL rst_in_rpt: got st=%0d want 3", dbg_state); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (pos_x !== 10'd320 || dbg_state !== ST_IDLE || dbg_cnt !== 4'd0) $display("FAIL rst_async: got x=%0d st=%0d cnt=%0d want 320/0/0", pos_x, dbg_state, dbg_cnt); else pass_cnt++;
    dir = 3'd0;
    @(negedge sys_clk);
    reset_n = 1'b1;
    do_tick(); do_tick();
    wait_cyc(2);
    total_cnt++; if (mv_seen - snap_mv !== 0 || pos_x !== 10'd320) $display("FAIL rst_no_pulse: got pulses=%0d x=%0d want 0/320", mv_seen - snap_mv, pos_x); else pass_cnt++;
  endtask

  task automatic test_reset_in_move();
    dir = 3'd4;
    wait_cyc(1);
    snap_mv = mv_seen;
    do_tick(); do_tick(); do_tick();
    total_cnt++; if (dbg_state !== ST_MOVE) $display("FAIL move_state: got st=%0d want 2", dbg_state); else pass_cnt++;
    #1 reset_n = 1'b0;
    @(negedge sys_clk);
    reset_n = 1'b1;
    dir = 3'd0;
    wait_cyc(2);
    total_cnt++; if (pos_x !== 10'd320 || mv_seen - snap_mv !== 0 || dbg_state !== ST_IDLE) $display("FAIL move_discard: got x=%0d pulses=%0d st=%0d want 320/0/0", pos_x, mv_seen - snap_mv, dbg_state); else pass_cnt++;
    dir = 3'd4;
    do_tick(); do_tick(); do_tick();
    @(negedge sys_clk);
    total_cnt++; if (pos_x !== 10'd324 || move_valid !== 1'b1) $display("FAIL resume: got x=%0d mv=%b want 324/1", pos_x, move_valid); else pass_cnt++;
    dir = 3'd0;
    do_tick();
  endtask

  task automatic test_no_overlap();
    wait_cyc(2);
    total_cnt++; if (both_seen !== 0) $display("FAIL valid_overlap: got %0d cycles want 0", both_seen); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_short_hold();
    test_clamp();
    test_select();
    test_mode_toggle();
    test_reset_mid_rpt();
    test_reset_in_move();
    test_no_overlap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dir_motion_ctrl.md
DIR_MOTION_CTRL -- requirements
Module: dir_motion_ctrl

Interface
REQ-001 SHALL have parameter X_MIN, default 0, minimum cursor x.
REQ-002 SHALL have parameter X_MAX, default 639, maximum cursor x.
REQ-003 SHALL have parameter Y_MIN, default 0, minimum cursor y.
REQ-004 SHALL have parameter Y_MAX, default 479, maximum cursor y.
REQ-005 SHALL have parameter X_INIT, default 320, and parameter Y_INIT, default 240, the reset position.
REQ-006 SHALL have parameter STEP, default 4, pixels moved per action.
REQ-007 SHALL have parameter HOLD, default 3 (legal values 2..15), the number of consecutive frames a command must be stable before the first action.
REQ-008 SHALL have parameter REPEAT, default 8 (legal values 1..15), the number of frames between repeated actions while the command is held.
REQ-009 SHALL have parameter SEL_COUNT, default 5 (legal values 2..8), the number of selectable items.
REQ-010 SHALL have port sys_clk, input, 1 bit, the single clock.
REQ-011 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-012 SHALL have port frame_tick, input, 1 bit, a one-cycle pulse once per video frame.
REQ-013 SHALL have port pickMode, input, 1 bit: 1 = selection mode, 0 = movement mode.
REQ-014 SHALL have port dir, input, 3 bits: 0 idle, 1 up, 2 down, 3 left, 4 right, 5..7 idle.
REQ-015 SHALL have port LRdir, input, 3 bits: 0 idle, 1 previous, 2 next, 3..7 idle.
REQ-016 SHALL have ports pos_x and pos_y, outputs, 10 bits each, the registered cursor position.
REQ-017 SHALL have port sel_idx, output, 3 bits, the registered selection index.
REQ-018 SHALL have ports move_valid and sel_valid, outputs, 1 bit each, registered one-cycle pulses.

Function
REQ-019 Effective command SHALL be {pickMode, pickMode ? LRdir : dir}; any code defined as idle for the active mode SHALL count as NONE.
REQ-020 The command SHALL be sampled only in cycles where frame_tick=1.
REQ-021 The FSM SHALL have exactly four states: IDLE, ARM, MOVE and RPT, plus a 4-bit frame counter cnt and a latched command lcmd.
REQ-022 IDLE: on a tick with cmd≠NONE, SHALL latch lcmd=cmd, set cnt=1 and go to ARM.
REQ-023 ARM, on a tick:
- cmd=NONE: SHALL go to IDLE.
- cmd≠lcmd and cmd≠NONE: SHALL relatch lcmd, set cnt=1 and stay in ARM.
- cmd=lcmd: SHALL increment cnt; when cnt reaches HOLD, SHALL go to MOVE.
REQ-024 MOVE SHALL last exactly one cycle, apply the lcmd action, clear cnt and go to RPT; a frame_tick arriving in this cycle SHALL be ignored.
REQ-025 RPT, on a tick:
- cmd≠lcmd: SHALL go to IDLE.
- cmd=lcmd: SHALL increment cnt; when cnt reaches REPEAT, SHALL go to MOVE.
REQ-026 Up/down/left/right actions SHALL compute in 11-bit arithmetic, saturating at Y_MIN/Y_MAX/X_MIN/X_MAX with no wrap or underflow.
REQ-027 move_valid SHALL pulse for exactly the first cycle the new position is visible, only if pos_x or pos_y actually changed; a clamped no-op SHALL produce no pulse.
REQ-028 The previous action SHALL set sel_idx to SEL_COUNT-1 when it is 0, otherwise to sel_idx-1; the next action SHALL set sel_idx to 0 when it is SEL_COUNT-1, otherwise to sel_idx+1.
REQ-029 sel_valid SHALL pulse on every select action, in the first cycle the new index is visible.
REQ-030 New outputs SHALL be visible two clock edges after the tick that completes HOLD or REPEAT.
REQ-031 A pickMode toggle SHALL change cmd and therefore restart or abort per REQ-023 and REQ-025, even when the numeric code is unchanged.
REQ-032 Movement actions SHALL never alter sel_idx, and select actions SHALL never alter pos_x or pos_y.
REQ-033 move_valid and sel_valid SHALL never both be 1 in the same cycle.

Reset
REQ-034 While reset_n=0, outputs SHALL immediately, without a clock, become: pos_x=X_INIT, pos_y=Y_INIT, sel_idx=0, move_valid=0, sel_valid=0, state IDLE, cnt=0, lcmd=NONE.
REQ-035 A reset asserted in any state, including MOVE, SHALL discard the pending action.
REQ-036 Operation SHALL resume on the first tick after reset_n rises.

Verification (defaults unless stated)
REQ-037 dir=4 held for 3 ticks -> pos_x=324 with one move_valid pulse; held 8 more ticks -> pos_x=328 with a second pulse.
REQ-038 dir=1 held for 2 ticks, then dir=0 -> pos_y stays 240 and no pulse.
REQ-039 With Y_INIT=2, dir=1 held for 11 ticks -> pos_y=0 with a pulse at tick 3, and no pulse at tick 11.
REQ-040 pickMode=1 with sel_idx=0, LRdir=1 held for 3 ticks -> sel_idx=4 with a sel_valid pulse; then LRdir=2 held for 3 ticks -> sel_idx=0.
REQ-041 dir=2 with pickMode toggling 0->1 after tick 2, and LRdir=2 -> no move; the first select action occurs at tick 5.
REQ-042 reset_n pulsed low mid-RPT after pos_x=324 -> pos_x=320 in the same cycle, and no pulse follows.
